reset_sequencer: RTL

Synthesizable, clocked successor to the behavioural reset source for csp2verilog runtime benches and emitted designs. It takes one asynchronous active-low reset and produces three ordered groups of active-low reset outputs: RESETS, then STARTS, then DELAYS. Each group is released after a parametrised number of clock cycles. All outputs assert asynchronously, release synchronously, and the sequence can be re-run from a software request without external reset.

---
 rtl/reset_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// reset_sequencer
// Turns one asynchronous active-low reset into three ordered groups of
// active-low reset outputs: RESETS first, then STARTS, then DELAYS. Each group
// releases a programmable number of clock cycles after the one before it.
// All outputs clear asynchronously and release synchronously.
//
// Optional feature (compile-time macro RESET_SEQ_SW_REQ_EN):
//   Adds the sw_req input. While sw_req is sampled high, the sequencer holds
//   every output in reset. The sequence reruns from the first edge that
//   samples sw_req low. It does not wait for the reset synchronizer again.
//   reset_n always overrides sw_req.

module reset_sequencer #(
  parameter int RESETS       = 1,
  parameter int STARTS       = 0,
  parameter int DELAYS       = 0,
  parameter int SYNC_STAGES  = 2,
  parameter int RESET_CYCLES = 10,
  parameter int START_CYCLES = 10,
  parameter int DELAY_CYCLES = 10
) (
  input  logic                             clk,
  input  logic                             reset_n,
`ifdef RESET_SEQ_SW_REQ_EN
  input  logic                             sw_req,
`endif
  output logic [RESETS+STARTS+DELAYS-1:0]  rst_out_n,
  output logic                             done
);

  localparam int W       = RESETS + STARTS + DELAYS;
  localparam int MAX_RS  = (RESET_CYCLES > START_CYCLES) ? RESET_CYCLES : START_CYCLES;
  localparam int MAX_CYC = (MAX_RS > DELAY_CYCLES) ? MAX_RS : DELAY_CYCLES;
  localparam int CW      = $clog2(MAX_CYC + 1);

  // The state register's HOLD exit acts as the final synchronizer stage.
  // That is why the explicit chain is one flop shorter than SYNC_STAGES.
  localparam int SL = SYNC_STAGES - 1;

  // Parameter sanity: refuse to elaborate nonsensical configurations.
  if (RESETS < 1) begin : g_err_resets
    $error("reset_sequencer: RESETS must be >= 1");
  end
  if (STARTS < 0 || DELAYS < 0) begin : g_err_widths
    $error("reset_sequencer: STARTS and DELAYS must be >= 0");
  end
  if (SYNC_STAGES < 2) begin : g_err_sync
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (RESET_CYCLES < 1 || START_CYCLES < 1 || DELAY_CYCLES < 1) begin : g_err_cycles
    $error("reset_sequencer: all *_CYCLES parameters must be >= 1");
  end

  // Builds a W-bit mask with n ones starting at bit lo.
  // An empty group (n == 0) yields an all-zero mask, so no zero-width slice is needed.
  function automatic logic [W-1:0] group_mask(input int lo, input int n);
    logic [W-1:0] m;
    m = '0;
    for (int i = 0; i < n; i++) begin
      m[lo + i] = 1'b1;
    end
    return m;
  endfunction

  localparam logic [W-1:0]  MASK_R   = group_mask(0, RESETS);
  localparam logic [W-1:0]  MASK_S   = group_mask(RESETS, STARTS);
  localparam logic [W-1:0]  MASK_D   = group_mask(RESETS + STARTS, DELAYS);

  // The counter starts at 0 on the entry edge and is compared before the increment.
  // It therefore reaches the count N on the edge where it holds N-1.
  localparam logic [CW-1:0] LAST_R   = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0] LAST_S   = CW'(START_CYCLES - 1);
  localparam logic [CW-1:0] LAST_D   = CW'(DELAY_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [SL-1:0] SYNC_ONE = SL'(1);

  typedef enum logic [2:0] {
    S_HOLD   = 3'd0,
    S_WAIT_R = 3'd1,
    S_WAIT_S = 3'd2,
    S_WAIT_D = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Empty groups are skipped at elaboration time. Their wait states are then never entered.
  localparam state_t AFTER_R = (STARTS > 0) ? S_WAIT_S :
                               (DELAYS > 0) ? S_WAIT_D : S_DONE;
  localparam state_t AFTER_S = (DELAYS > 0) ? S_WAIT_D : S_DONE;

  logic [SL-1:0] r_sync;
  logic          w_sync_ready;
  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0]  r_rst_out;
  logic          r_done;

  // Deassertion synchronizer: clears instantly with reset_n and shifts in ones afterwards.
  // NOTE: sequential state uses non-blocking (<=) so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= (r_sync << 1) | SYNC_ONE;
    end
  end

  assign w_sync_ready = r_sync[SL-1];

  // Release sequencer: walks the groups in order and registers every output.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_rst_out <= '0;
      r_done    <= 1'b0;
    end
`ifdef RESET_SEQ_SW_REQ_EN
    else if (sw_req) begin
      r_state   <= S_HOLD;
      r_cnt     <= '0;
      r_rst_out <= '0;
      r_done    <= 1'b0;
    end
`endif
    else begin
      case (r_state)
        S_HOLD: begin
          if (w_sync_ready) begin
            r_state <= S_WAIT_R;
          end
        end

        S_WAIT_R: begin
          if (r_cnt == LAST_R) begin
            r_cnt     <= '0;
            r_rst_out <= r_rst_out | MASK_R;
            r_state   <= AFTER_R;
            r_done    <= (AFTER_R == S_DONE);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_WAIT_S: begin
          if (r_cnt == LAST_S) begin
            r_cnt     <= '0;
            r_rst_out <= r_rst_out | MASK_S;
            r_state   <= AFTER_S;
            r_done    <= (AFTER_S == S_DONE);
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_WAIT_D: begin
          if (r_cnt == LAST_D) begin
            r_cnt     <= '0;
            r_rst_out <= r_rst_out | MASK_D;
            r_state   <= S_DONE;
            r_done    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        S_DONE: begin
          r_done <= 1'b1;
        end

        // NOTE: unused encodings fall back to a safe state instead of locking up.
        default: begin
          r_state   <= S_HOLD;
          r_cnt     <= '0;
          r_rst_out <= '0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign rst_out_n = r_rst_out;
  assign done      = r_done;

endmodule
